// File: rtl/spi_xact_seq.sv
`default_nettype none
// ============================================================================
// Module   : spi_xact_seq
// Brief    : Register-access transaction sequencer in front of a byte-wide
//            SPI master. Sends a header {rw, burst, addr} followed by len data
//            bytes, framing them with chip-select setup/hold delays and a
//            per-byte timeout.
// Revision : 1.0  initial release
// ============================================================================
module spi_xact_seq #(
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       rw,
  input  logic [5:0] addr,
  input  logic [3:0] len,
  input  logic [7:0] wr_data,
  output logic       wr_pop,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [7:0] status,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       cs_n,
  output logic       spi_start,
  output logic [7:0] spi_data_in,
  input  logic [7:0] spi_data_out,
  input  logic       spi_new_data
);

  // One shared wait timer serves setup, transfer timeout and hold.
  localparam int C_MAX_SH = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int C_MAXC   = (TIMEOUT > C_MAX_SH) ? TIMEOUT : C_MAX_SH;
  localparam int C_TW     = $clog2(C_MAXC + 1);

  localparam logic [C_TW-1:0] C_SETUP_LAST = C_TW'(CS_SETUP - 1);
  localparam logic [C_TW-1:0] C_HOLD_LAST  = C_TW'(CS_HOLD - 1);
  localparam logic [C_TW-1:0] C_TO_LAST    = C_TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            rw_q, rw_d;
  logic [3:0]      len_q, len_d;
  logic [3:0]      bcnt_q, bcnt_d;     // index of byte in flight: 0 = header
  logic [C_TW-1:0] tmr_q, tmr_d;
  logic            err_q, err_d;
  logic            cs_n_q, cs_n_d;
  logic [7:0]      sdi_q, sdi_d;
  logic [7:0]      rdd_q, rdd_d;
  logic            rdv_q, rdv_d;
  logic [7:0]      stat_q, stat_d;
  logic            w_final;

  // Final byte is the header for len=0, otherwise data byte number len.
  assign w_final = (bcnt_q == len_q);

  // Next-state and pulse outputs of the transaction sequencer.
  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    len_d     = len_q;
    bcnt_d    = bcnt_q;
    tmr_d     = tmr_q;
    err_d     = err_q;
    cs_n_d    = cs_n_q;
    sdi_d     = sdi_q;
    rdd_d     = rdd_q;
    rdv_d     = 1'b0;
    stat_d    = stat_q;
    wr_pop    = 1'b0;
    spi_start = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          rw_d    = rw;
          len_d   = len;
          sdi_d   = {rw, (len > 4'd1), addr};
          bcnt_d  = 4'd0;
          err_d   = 1'b0;
          cs_n_d  = 1'b0;
          tmr_d   = '0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (tmr_q == C_SETUP_LAST) begin
          tmr_d   = '0;
          state_d = XFER;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      XFER: begin
        spi_start = 1'b1;
        if (spi_new_data) begin
          tmr_d = '0;
          if (bcnt_q == 4'd0) begin
            stat_d = spi_data_out;
          end else if (rw_q) begin
            rdd_d = spi_data_out;
            rdv_d = 1'b1;
          end
          if (w_final) begin
            // Drop the start level now so the master does not begin another byte.
            spi_start = 1'b0;
            state_d   = HOLD;
          end else begin
            bcnt_d = bcnt_q + 4'd1;
            sdi_d  = rw_q ? 8'h00 : wr_data;
            wr_pop = ~rw_q;
          end
        end else if (tmr_q == C_TO_LAST) begin
          err_d   = 1'b1;
          tmr_d   = '0;
          state_d = HOLD;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      HOLD: begin
        if (tmr_q == C_HOLD_LAST) begin
          tmr_d   = '0;
          cs_n_d  = 1'b1;
          state_d = FIN;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by the low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      len_q   <= 4'd0;
      bcnt_q  <= 4'd0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      sdi_q   <= 8'h00;
      rdd_q   <= 8'h00;
      rdv_q   <= 1'b0;
      stat_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      len_q   <= len_d;
      bcnt_q  <= bcnt_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      cs_n_q  <= cs_n_d;
      sdi_q   <= sdi_d;
      rdd_q   <= rdd_d;
      rdv_q   <= rdv_d;
      stat_q  <= stat_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign err         = err_q;
  assign cs_n        = cs_n_q;
  assign spi_data_in = sdi_q;
  assign rd_data     = rdd_q;
  assign rd_valid    = rdv_q;
  assign status      = stat_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_xact_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_xact_seq
// Brief    : Self-checking bench for spi_xact_seq with a behavioural SPI
//            slave, a write-data source and an expected-transaction model.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_xact_seq;

  localparam int CS_SETUP = 3;
  localparam int CS_HOLD  = 5;
  localparam int TIMEOUT  = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       rw;
  logic [5:0] addr;
  logic [3:0] len;
  logic [7:0] wr_data;
  logic       wr_pop;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] status;
  logic       busy;
  logic       done;
  logic       err;
  logic       cs_n;
  logic       spi_start;
  logic [7:0] spi_data_in;
  logic [7:0] spi_data_out;
  logic       spi_new_data;

  always #5 clk = ~clk;

  spi_xact_seq #(
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .rw          (rw),
    .addr        (addr),
    .len         (len),
    .wr_data     (wr_data),
    .wr_pop      (wr_pop),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .status      (status),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .cs_n        (cs_n),
    .spi_start   (spi_start),
    .spi_data_in (spi_data_in),
    .spi_data_out(spi_data_out),
    .spi_new_data(spi_new_data)
  );

  int n_vec = 0;
  int n_err = 0;

  // Slave / source / monitor state
  logic [7:0] sent_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] wq[$];
  logic [7:0] resp_q[$];
  logic [7:0] src_wr[$];
  logic [7:0] src_resp[$];
  bit         spi_en = 1'b1;
  bit         m_busy;
  int         m_dly;
  bit         pop_pend;
  logic       prev_cs, prev_start;
  int cyc, n_pop, n_rdv, n_done, n_start_hi;
  int cs_fall_s, cs_rise_s, start_rise_s, last_nd_s, done_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SPI slave, write-data source and output monitor, all on the falling edge.
  initial begin
    spi_new_data = 1'b0; spi_data_out = 8'h00; wr_data = 8'h00;
    m_busy = 0; m_dly = 0; pop_pend = 0; cyc = 0;
    prev_cs = 1'b1; prev_start = 1'b0;
    n_pop = 0; n_rdv = 0; n_done = 0; n_start_hi = 0;
    cs_fall_s = -1; cs_rise_s = -1; start_rise_s = -1; last_nd_s = -1; done_s = -1;
    forever begin
      @(negedge clk);
      cyc++;
      spi_new_data = 1'b0;
      if (pop_pend) begin
        if (wq.size() > 0) void'(wq.pop_front());
        pop_pend = 0;
      end
      wr_data = (wq.size() > 0) ? wq[0] : 8'h00;
      if (!rst) begin
        m_busy = 0;
      end else if (m_busy) begin
        if (m_dly == 0) begin
          spi_new_data = 1'b1;
          spi_data_out = (resp_q.size() > 0) ? resp_q.pop_front() : 8'($urandom);
          m_busy = 0;
        end else begin
          m_dly--;
        end
      end else if (spi_en && spi_start) begin
        sent_q.push_back(spi_data_in);
        m_busy = 1;
        m_dly  = $urandom_range(0, 3);
      end
      #1;
      if (wr_pop) begin n_pop++; pop_pend = 1; end
      if (rd_valid) begin n_rdv++; rd_q.push_back(rd_data); end
      if (done) begin n_done++; done_s = cyc; end
      if (spi_new_data && busy && !spi_start) last_nd_s = cyc;
      if (spi_start) n_start_hi++;
      if (prev_cs && !cs_n) cs_fall_s = cyc;
      if (!prev_cs && cs_n) cs_rise_s = cyc;
      if (!prev_start && spi_start && start_rise_s < 0) start_rise_s = cyc;
      prev_cs = cs_n;
      prev_start = spi_start;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cs_n"}, 32'(cs_n), 32'd1);
    chk({tag, "_spi_start"}, 32'(spi_start), 32'd0);
    chk({tag, "_spi_data_in"}, 32'(spi_data_in), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_status"}, 32'(status), 32'd0);
    chk({tag, "_pulses"}, {29'd0, wr_pop, rd_valid, done}, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic clear_mon();
    sent_q.delete(); rd_q.delete();
    n_start_hi = 0; start_rise_s = -1; last_nd_s = -1;
    cs_fall_s = -1; cs_rise_s = -1; done_s = -1;
  endtask

  task automatic wait_done(input int d0, input int bound);
    for (int i = 0; i < bound && n_done == d0; i++) @(negedge clk);
  endtask

  // Runs one transaction using src_wr/src_resp and checks it against the
  // expected byte stream derived from (rw, addr, len).
  task automatic run_xact(input bit r, input logic [5:0] a, input logic [3:0] l, input bit inj);
    logic [7:0] exp_sent[$];
    int d0, p0, v0, n;
    clear_mon();
    wq = src_wr;
    resp_q = src_resp;
    exp_sent.push_back(8'((r ? 128 : 0) + ((l > 4'd1) ? 64 : 0) + int'(a)));
    for (int i = 1; i <= int'(l); i++) exp_sent.push_back(r ? 8'h00 : src_wr[i-1]);
    d0 = n_done; p0 = n_pop; v0 = n_rdv;
    @(negedge clk); rw = r; addr = a; len = l; req = 1'b1;
    @(negedge clk); req = 1'b0;
    if (inj) begin
      @(negedge clk); req = 1'b1; rw = ~r; addr = ~a; len = l + 4'd1;
      @(negedge clk); req = 1'b0;
      for (int i = 0; i < 400 && last_nd_s < 0; i++) @(negedge clk);
      @(negedge clk); req = 1'b1;
      @(negedge clk); req = 1'b0;
    end
    wait_done(d0, 400);
    repeat (3) @(negedge clk);
    chk("done_count", 32'(n_done - d0), 32'd1);
    chk("byte_count", 32'(sent_q.size()), 32'(int'(l) + 1));
    n = (sent_q.size() < exp_sent.size()) ? sent_q.size() : exp_sent.size();
    for (int i = 0; i < n; i++) chk($sformatf("spi_byte%0d", i), 32'(sent_q[i]), 32'(exp_sent[i]));
    chk("status", 32'(status), 32'(src_resp[0]));
    chk("wr_pop_count", 32'(n_pop - p0), r ? 32'd0 : 32'(l));
    chk("rd_valid_count", 32'(n_rdv - v0), r ? 32'(l) : 32'd0);
    if (r) begin
      n = (rd_q.size() < int'(l)) ? rd_q.size() : int'(l);
      for (int i = 0; i < n; i++) chk($sformatf("rd_data%0d", i), 32'(rd_q[i]), 32'(src_resp[i+1]));
    end
    chk("cs_setup_gap", 32'(start_rise_s - cs_fall_s), 32'(CS_SETUP));
    chk("cs_hold_gap", 32'(cs_rise_s - last_nd_s), 32'(CS_HOLD + 1));
    chk("done_at_cs_rise", 32'(done_s), 32'(cs_rise_s));
    chk("end_err", 32'(err), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_cs_n", 32'(cs_n), 32'd1);
  endtask

  task automatic rand_src(input int l);
    src_wr.delete(); src_resp.delete();
    for (int i = 0; i < l; i++) src_wr.push_back(8'($urandom));
    for (int i = 0; i <= l; i++) src_resp.push_back(8'($urandom));
  endtask

  initial begin
    int d0, p0, v0;
    rst = 1'b0; req = 1'b0; rw = 1'b0; addr = 6'h00; len = 4'h0;
    #22;
    check_reset_outputs("por");
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed write: 4A, 11, 22
    src_wr = '{8'h11, 8'h22};
    src_resp = '{8'h5A, 8'h66, 8'h77};
    run_xact(1'b0, 6'h0A, 4'd2, 1'b0);

    // Directed read: header FF, status A5, data 01 02 03
    src_wr.delete();
    src_resp = '{8'hA5, 8'h01, 8'h02, 8'h03};
    run_xact(1'b1, 6'h3F, 4'd3, 1'b0);

    // Header-only read: byte 85, no rd_valid
    src_resp = '{8'h3C};
    run_xact(1'b1, 6'h05, 4'd0, 1'b0);

    // Requests during SETUP and HOLD are ignored
    rand_src(4);
    run_xact(1'b0, 6'h21, 4'd4, 1'b1);

    // Longest burst, both directions
    rand_src(15);
    run_xact(1'b0, 6'h2C, 4'd15, 1'b0);
    rand_src(15);
    run_xact(1'b1, 6'h13, 4'd15, 1'b1);

    // Timeout: slave never answers
    spi_en = 1'b0;
    clear_mon();
    d0 = n_done;
    @(negedge clk); rw = 1'b1; addr = 6'h11; len = 4'd2; req = 1'b1;
    @(negedge clk); req = 1'b0;
    wait_done(d0, TIMEOUT + 100);
    chk("to_done", 32'(n_done - d0), 32'd1);
    chk("to_start_cycles", 32'(n_start_hi), 32'(TIMEOUT));
    repeat (4) @(negedge clk);
    chk("to_err_held", 32'(err), 32'd1);
    chk("to_cs_n", 32'(cs_n), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    spi_en = 1'b1;
    rand_src(1);
    run_xact(1'b0, 6'h01, 4'd1, 1'b0);

    // Reset in the middle of a transfer
    rand_src(15);
    clear_mon();
    wq = src_wr; resp_q = src_resp;
    @(negedge clk); rw = 1'b0; addr = 6'h30; len = 4'd15; req = 1'b1;
    @(negedge clk); req = 1'b0;
    for (int i = 0; i < 200 && sent_q.size() < 3; i++) @(negedge clk);
    chk("mid_in_xfer", 32'(spi_start | dut.spi_new_data), 32'd1);
    #3 rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    d0 = n_done; p0 = n_pop; v0 = n_rdv;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wq.delete(); resp_q.delete();
    repeat (5) @(negedge clk);
    chk("post_rst_pulses", 32'((n_done - d0) + (n_pop - p0) + (n_rdv - v0)), 32'd0);
    chk("post_rst_cs_n", 32'(cs_n), 32'd1);

    // Randomized transactions
    for (int k = 0; k < 8; k++) begin
      bit         r;
      logic [5:0] a;
      logic [3:0] l;
      r = 1'($urandom);
      a = 6'($urandom);
      l = 4'($urandom);
      rand_src(int'(l));
      run_xact(r, a, l, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
